// File: rtl/cache_pkg.sv
// Shared geometry, line record and word-access helpers for the direct-mapped cache.
package cache_pkg;
  localparam int LINES  = 4;
  localparam int WORDS  = 4;
  localparam int TAG_W  = 4;
  localparam int IDX_W  = 2;
  localparam int OFF_W  = 2;
  localparam int WORD_W = 32;
  localparam int LINE_W = WORDS * WORD_W;
  localparam int BLK_W  = TAG_W + IDX_W;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } line_t;

  function automatic logic [WORD_W-1:0] word_of(input logic [LINE_W-1:0] d,
                                                input logic [OFF_W-1:0]  off);
    return d[int'(off)*WORD_W +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] d,
                                                 input logic [OFF_W-1:0]  off,
                                                 input logic [WORD_W-1:0] w);
    logic [LINE_W-1:0] r;
    r = d;
    r[int'(off)*WORD_W +: WORD_W] = w;
    return r;
  endfunction
endpackage

// File: rtl/cache_unit.sv
// Direct-mapped, write-back, write-allocate cache: 4 lines x 4 words, flop storage,
// combinational lookup/write-back/debug paths, refill and store on the rising edge.
module cache_unit
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                update,
  input  logic [31:0]         addr,
  input  logic [WORD_W-1:0]   wdata,
  input  logic [LINE_W-1:0]   fill_data,
  input  logic                memwrite,
  input  logic [IDX_W-1:0]    dbg_line,
  input  logic [OFF_W-1:0]    dbg_word,
  output logic [WORD_W-1:0]   dbg_data,
  output logic                dbg_dirty,
  output logic [WORD_W-1:0]   rdata,
  output logic                miss,
  output logic                victim_dirty,
  output logic [LINE_W-1:0]   wb_data,
  output logic [BLK_W-1:0]    wb_addr
);

  line_t lines_q [LINES];
  line_t lines_d [LINES];

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  line_t            cur;
  logic             unused_addr_hi;

  assign off = addr[OFF_W-1:0];
  assign idx = addr[OFF_W +: IDX_W];
  assign tag = addr[OFF_W+IDX_W +: TAG_W];
  // Upper address bits alias onto the same block.
  assign unused_addr_hi = ^addr[31:OFF_W+IDX_W+TAG_W];

  assign cur          = lines_q[idx];
  assign miss         = !cur.valid || (cur.tag != tag);
  assign rdata        = word_of(cur.data, off);
  assign victim_dirty = cur.valid && cur.dirty;
  assign wb_data      = cur.data;
  assign wb_addr      = {cur.tag, idx};

  assign dbg_data  = word_of(lines_q[dbg_line].data, dbg_word);
  assign dbg_dirty = lines_q[dbg_line].dirty;

  // Refill wins over a coincident store; a store on a miss is dropped until refill.
  always_comb begin
    lines_d = lines_q;
    if (update) begin
      lines_d[idx].valid = 1'b1;
      lines_d[idx].dirty = 1'b0;
      lines_d[idx].tag   = tag;
      lines_d[idx].data  = fill_data;
    end else if (memwrite && !miss) begin
      lines_d[idx].dirty = 1'b1;
      lines_d[idx].data  = put_word(lines_q[idx].data, off, wdata);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) lines_q[i] <= '0;
    end else begin
      lines_q <= lines_d;
    end
  end

endmodule

// File: tb/tb_cache_unit.sv
// Directed bench for cache_unit with hand-computed expectations.
module tb_cache_unit;
  logic         clk = 1'b0;
  logic         reset;
  logic         update;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [127:0] fill_data;
  logic         memwrite;
  logic [1:0]   dbg_line;
  logic [1:0]   dbg_word;
  logic [31:0]  dbg_data;
  logic         dbg_dirty;
  logic [31:0]  rdata;
  logic         miss;
  logic         victim_dirty;
  logic [127:0] wb_data;
  logic [5:0]   wb_addr;

  int checks = 0;
  int failures = 0;

  cache_unit dut (
    .clk(clk), .reset(reset), .update(update), .addr(addr), .wdata(wdata),
    .fill_data(fill_data), .memwrite(memwrite), .dbg_line(dbg_line),
    .dbg_word(dbg_word), .dbg_data(dbg_data), .dbg_dirty(dbg_dirty),
    .rdata(rdata), .miss(miss), .victim_dirty(victim_dirty),
    .wb_data(wb_data), .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg(input logic [1:0] l, input logic [1:0] w);
    dbg_line = l;
    dbg_word = w;
    #1;
  endtask

  initial begin
    reset = 1'b1; update = 1'b0; memwrite = 1'b0; addr = 32'h0;
    wdata = 32'h0; fill_data = '0; dbg_line = 2'd0; dbg_word = 2'd0;
    step(); step();
    chk("rst_miss", miss, 1);
    chk("rst_vdirty", victim_dirty, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wbaddr", wb_addr, 6'h00);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_dbg", dbg_data, 0);
    addr = 32'h0C; #1;
    chk("rst_wbaddr_idx3", wb_addr, 6'h03);

    reset = 1'b0;
    step();
    // Store on a miss is ignored
    addr = 32'h80; wdata = 32'hFEEDFACE; memwrite = 1'b1;
    step();
    memwrite = 1'b0; #1;
    chk("missst_miss", miss, 1);
    dbg(2'd0, 2'd0);
    chk("missst_dirty", dbg_dirty, 0);
    chk("missst_data", dbg_data, 0);

    // Refill line 1 with tag 2
    addr = 32'h25;
    fill_data = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
    update = 1'b1;
    step();
    update = 1'b0; #1;
    chk("fill_miss", miss, 0);
    chk("fill_rdata", rdata, 32'hDEADBEEF);
    chk("fill_wbaddr", wb_addr, 6'h09);
    chk("fill_vdirty", victim_dirty, 0);
    dbg(2'd1, 2'd1);
    chk("fill_dbg", dbg_data, 32'hDEADBEEF);
    chk("fill_dbgdirty", dbg_dirty, 0);

    // Store hit to word 2
    addr = 32'h26; wdata = 32'h12345678; memwrite = 1'b1;
    step();
    memwrite = 1'b0; #1;
    chk("st_rdata", rdata, 32'h12345678);
    chk("st_vdirty", victim_dirty, 1);
    addr = 32'h25; #1;
    chk("st_w1_kept", rdata, 32'hDEADBEEF);

    // Second store to dirty line, word 0
    addr = 32'h24; wdata = 32'hAAAA0000; memwrite = 1'b1;
    step();
    memwrite = 1'b0;
    dbg(2'd1, 2'd0);
    chk("st2_dbg", dbg_data, 32'hAAAA0000);
    chk("st2_dirty", dbg_dirty, 1);

    // Conflict miss: victim visible before refill
    addr = 32'h66; #1;
    chk("vic_miss", miss, 1);
    chk("vic_vdirty", victim_dirty, 1);
    chk("vic_wbaddr", wb_addr, 6'h09);
    chk("vic_wbw2", wb_data[95:64], 32'h12345678);
    chk("vic_wbdata", wb_data, {32'h33333333, 32'h12345678, 32'hDEADBEEF, 32'hAAAA0000});
    fill_data = {32'h44444444, 32'hCAFEF00D, 32'h55555555, 32'h66666666};
    update = 1'b1;
    step();
    update = 1'b0; #1;
    chk("refill_wbaddr", wb_addr, 6'h19);
    chk("refill_miss", miss, 0);
    chk("refill_rdata", rdata, 32'hCAFEF00D);
    chk("refill_vdirty", victim_dirty, 0);
    dbg(2'd1, 2'd2);
    chk("refill_dbgdirty", dbg_dirty, 0);

    // Upper address bits alias
    addr = 32'hFFFFFF66; #1;
    chk("alias_miss", miss, 0);
    chk("alias_rdata", rdata, 32'hCAFEF00D);

    // Update and store together: refill wins
    addr = 32'h10; wdata = 32'hBAD0BAD0;
    fill_data = {32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A, 32'h09090909};
    update = 1'b1; memwrite = 1'b1;
    step();
    update = 1'b0; memwrite = 1'b0; #1;
    chk("both_wbdata", wb_data, {32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A, 32'h09090909});
    chk("both_miss", miss, 0);
    dbg(2'd0, 2'd0);
    chk("both_dirty", dbg_dirty, 0);

    // Asynchronous reset mid-refill wins
    addr = 32'h30; fill_data = {4{32'h77777777}}; update = 1'b1;
    @(negedge clk);
    reset = 1'b1; #1;
    dbg(2'd1, 2'd2);
    chk("arst_dbg", dbg_data, 0);
    addr = 32'h66; #1;
    chk("arst_miss", miss, 1);
    step();
    update = 1'b0; reset = 1'b0;
    step();
    addr = 32'h30; #1;
    chk("arst_lost_miss", miss, 1);
    chk("arst_lost_wb", wb_data, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
